mem_port_arbiter: RTL

Shares the core's single-ported unified memory between the instruction-fetch port and the data-memory port. Each requester issues one transaction at a time using a req/gnt/rvalid handshake. The arbiter serializes the transactions and drives the memory's enable, write, address, data and mask lines. It returns read data or a write acknowledge to the port that was granted. It sits between the stage manager / control unit datapath and the memory macro.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, one transaction at a time.
// Latency: grant to rvalid is 2+LATENCY (read) or 2 (write); gnt only in IDLE, requesters hold req until granted.
module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t     state;
  logic       owner;        // 1 = data port owns the in-flight transaction
  logic       last_winner;  // 1 = data port won the previous grant
  logic [3:0] cnt;

  // On a conflict the port that lost last time wins.
  assign if_gnt = !rst && (state == IDLE) && if_req && (!dm_req || last_winner);
  assign dm_gnt = !rst && (state == IDLE) && dm_req && (!if_req || !last_winner);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_winner <= 1'b0;
      cnt         <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      busy        <= 1'b0;
      if_rvalid   <= 1'b0;
      dm_rvalid   <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            owner       <= dm_gnt;
            last_winner <= dm_gnt;
            mem_en      <= 1'b1;
            mem_we      <= dm_gnt & dm_we;
            mem_addr    <= dm_gnt ? dm_addr : if_addr;
            mem_wdata   <= dm_gnt ? dm_wdata : '0;
            mem_wmask   <= dm_gnt ? dm_wmask : '0;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // The mem_* registers double as the latched request; clear them once issued.
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wmask <= '0;
          if (mem_we) begin
            dm_rvalid <= owner;
            if_rvalid <= !owner;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (owner) begin
              dm_rdata  <= mem_rdata;
              dm_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
